// File: rtl/cpu_in_port.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_in_port
//  Purpose  : CPU IN byte port. Samples 8 raw GPIO pins, synchronises and
//             debounces them, and offers each newly accepted stable byte to
//             the CPU IN opcode through a ready/read handshake.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1  system clock, all state on rising edge
//    reset_i      in   1  asynchronous active-high reset
//    pins_i       in   8  raw asynchronous GPIO byte
//    clk_en_i     in   1  CPU clock enable, qualifies in_strobe_i
//    in_strobe_i  in   1  IN-opcode read strobe
//    in_value_o   out  8  latest accepted debounced byte
//    in_ready_o   out  1  an unread accepted byte is present
//    overrun_o    out  1  an accepted byte was replaced before being read
// ============================================================================
module cpu_in_port #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CNT = 16
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic [7:0] pins_i,
    input  logic       clk_en_i,
    input  logic       in_strobe_i,
    output logic [7:0] in_value_o,
    output logic       in_ready_o,
    output logic       overrun_o
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CNT - 1);

    // Synchronizer chain; index SYNC_STAGES-1 is the oldest (settled) stage.
    logic [SYNC_STAGES-1:0][7:0] sync_chain;
    logic [7:0]                  sync;

    logic [7:0]       candidate;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       stable;

    logic accept;
    logic rd;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], pins_i};
        end
    end

    assign sync = sync_chain[SYNC_STAGES-1];

    // Any change in the synchronised value restarts the count; the count
    // saturates so a long-steady input never re-triggers.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            candidate <= '0;
            cnt       <= '0;
        end else if (sync != candidate) begin
            candidate <= sync;
            cnt       <= '0;
        end else if (cnt < CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A glitch that settles back to the current stable value reaches
    // saturation with candidate == stable, so it never produces an event.
    assign accept = (cnt == CNT_MAX) && (sync == candidate) && (candidate != stable);
    assign rd     = in_strobe_i & clk_en_i;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            stable <= '0;
        end else if (accept) begin
            stable <= candidate;
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            in_value_o <= '0;
            in_ready_o <= 1'b0;
            overrun_o  <= 1'b0;
        end else if (accept) begin
            in_value_o <= candidate;
            if (rd) begin
                // The read on this edge consumed the previous byte.
                in_ready_o <= 1'b1;
                overrun_o  <= 1'b0;
            end else if (!in_ready_o) begin
                in_ready_o <= 1'b1;
            end else begin
                overrun_o  <= 1'b1;
            end
        end else if (rd) begin
            in_ready_o <= 1'b0;
            overrun_o  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/cpu_in_port.md
# cpu_in_port

Input-direction counterpart to the CPU's OUT byte port. Samples 8 raw GPIO pins, synchronizes and debounces them, and presents each new stable byte to `cpu_main`'s IN opcode through a ready/read handshake. It sits in the board top alongside the OUT pin mapping. All flops run on the single fast `clk`. Only the CPU read side is qualified by the CPU `clk_en_i`.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth, minimum 2.
- `DEBOUNCE_CNT`, default 16: number of consecutive `clk` cycles of identical synchronized input required to accept a value, minimum 1.

Ports (reset is asynchronous and active-high):
- `clk`  in  1  system clock; all state is updated on its rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `pins_i`  in  8  raw asynchronous GPIO input byte (`byte_t`).
- `clk_en_i`  in  1  CPU clock enable; qualifies `in_strobe_i`.
- `in_strobe_i`  in  1  IN-opcode read; acts only when `clk_en_i`=1.
- `in_value_o`  out  8  latest accepted debounced byte (`byte_t`).
- `in_ready_o`  out  1  an unread accepted byte is present.
- `overrun_o`  out  1  an accepted byte was replaced before being read.

## Operation
- **Synchronizer:** `SYNC_STAGES`-flop chain per bit, reset to 0. `sync` is the last stage.
- **Debounce:** internal `candidate` (8b), `cnt` (width `$clog2(DEBOUNCE_CNT+1)`), `stable` (8b). All reset to 0.
  - If `sync` != `candidate`: load `candidate` <= `sync` and `cnt` <= 0.
  - Else if `cnt` < `DEBOUNCE_CNT`-1: increment `cnt`.
  - `cnt` saturates at `DEBOUNCE_CNT`-1. It never wraps.
- **Accept event:** fires when `cnt` == `DEBOUNCE_CNT`-1, `sync` == `candidate`, and `candidate` != `stable`. On that edge, `stable` <= `candidate`.
- **Glitch rejection:** a glitch that returns to the old value before saturating restarts `cnt` and produces no event, because `candidate` == `stable`.
- **Read:** `rd` = `in_strobe_i` & `clk_en_i`. `in_strobe_i` with `clk_en_i`=0 is ignored.
- **Handshake, priority as listed:**
  - Accept and `rd` on the same edge: `in_value_o` <= new byte, `in_ready_o` <= 1, `overrun_o` <= 0. The read consumed the old byte.
  - Accept with `in_ready_o`=0: `in_value_o` <= new byte, `in_ready_o` <= 1.
  - Accept with `in_ready_o`=1 and no `rd`: `in_value_o` <= new byte (latest wins), `overrun_o` <= 1.
  - `rd` without accept: `in_ready_o` <= 0, `overrun_o` <= 0. `in_value_o` holds.
  - `rd` while `in_ready_o`=0: harmless. The same value is re-read.
- **Stable value:** `in_value_o` always equals `stable` after any accept.
- **Reset:** all outputs and internal state go to 0 asynchronously. Any in-progress debounce is discarded.
  - After reset release, pins steadily at 0x00 produce no event.
  - After reset release, any nonzero steady value produces one event.

## Timing
- Let t0 be the first rising edge that samples a new steady `pins_i` value.
  - `candidate` loads at edge t0+`SYNC_STAGES`.
  - The accept event occurs at edge t0+`SYNC_STAGES`+`DEBOUNCE_CNT`.
  - `in_ready_o` and `in_value_o` are valid after that edge. With defaults, that is edge t0+18. Not earlier.
- `rd` clears `in_ready_o` after the same edge on which it is sampled (1-edge latency).
- Outputs are registered. No combinational path from any input to any output.
- Reset values: `in_value_o`=0x00, `in_ready_o`=0, `overrun_o`=0.

## Test plan
- **Idle after reset:** assert `reset_i` mid-run, release, hold `pins_i`=0x00 for 100 cycles -> all outputs 0 throughout. While `reset_i` is asserted, outputs are 0 immediately, without waiting for a clock edge.
- **Latency:** step `pins_i` 0x00->0xA5 at t0 (defaults) -> `in_ready_o`=1 and `in_value_o`=0xA5 first seen after edge t0+18; both still 0 after edge t0+17.
- **Glitch:** pulse `pins_i`=0xFF for 10 cycles, then back to 0x00 -> no event; `in_ready_o` stays 0, `in_value_o` stays 0x00. Repeat with `DEBOUNCE_CNT`=1 -> a 2-cycle pulse is accepted.
- **Read:**
  - With 0xA5 pending, apply `in_strobe_i`=1 with `clk_en_i`=0 -> no change.
  - Then apply `in_strobe_i`=1 with `clk_en_i`=1 for one edge -> `in_ready_o`=0 and `in_value_o`=0xA5 next cycle.
- **Overrun:** accept 0x11, then 0x22 with no read -> `in_value_o`=0x22, `in_ready_o`=1, `overrun_o`=1. One read -> `in_ready_o`=0, `overrun_o`=0.
- **Simultaneous:** with 0x33 pending, apply `rd` on the exact accept edge of 0x44 -> `in_value_o`=0x44, `in_ready_o`=1, `overrun_o`=0. Also assert `reset_i` mid-debounce of 0x55 -> no event after release unless the pins remain 0x55, in which case the event arrives a full latency after release.
